// File: rtl/i2s_tx.sv
`timescale 1ns/1ps
// I2S / left-justified / TDM serial audio transmitter with a small sample FIFO.
// mclk and sck come from clk; the data/zero frame decision is made at each bit-index wrap.
module i2s_tx #(
   parameter int DATA_W     = 24,
   parameter int SLOT_W     = 32,
   parameter int CHANNELS   = 2,
   parameter int SCK_DIV    = 8,
   parameter int MCLK_DIV   = 4,
   parameter int FMT        = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [DATA_W-1:0]                 s_data,
   input  logic                              s_valid,
   output logic                              s_ready,
   output logic                              mclk,
   output logic                              sck,
   output logic                              lrck,
   output logic                              sdout,
   output logic                              underrun,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   level
);

   localparam int FB  = SLOT_W * CHANNELS;
   localparam int BW  = $clog2(FB);
   localparam int PW  = $clog2(SLOT_W);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = $clog2(FIFO_DEPTH + 1);
   localparam int SH  = SCK_DIV / 2;
   localparam int MH  = MCLK_DIV / 2;
   localparam int SCW = $clog2(SH + 1);
   localparam int MCW = $clog2(MH + 1);
   localparam logic [BW-1:0] B_LAST = BW'(FB - 1);
   localparam logic [BW-1:0] B_HALF = BW'(FB / 2);
   localparam logic [PW-1:0] P_LAST = PW'(SLOT_W - 1);

   logic [MCW-1:0]    r_mclk_cnt;
   logic              r_mclk;
   logic [SCW-1:0]    r_sck_cnt;
   logic              r_sck;
   logic [BW-1:0]     r_b;
   logic [PW-1:0]     r_pos;
   logic              r_frame_act;
   logic [SLOT_W-1:0] r_shift;
   logic              r_lj;
   logic              r_sdout;
   logic              r_lrck;
   logic              r_underrun;
   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr;
   logic [AW-1:0]     r_rd;
   logic [LW-1:0]     r_level;

   logic                     w_fall;
   logic                     w_wrap;
   logic [BW-1:0]            w_b_next;
   logic [BW-1:0]            w_b_next2;
   logic [PW-1:0]            w_pos_next;
   logic                     w_enough;
   logic                     w_act_next;
   logic                     w_pop;
   logic                     w_push;
   logic [DATA_W+SLOT_W-1:0] w_cat;
   logic [SLOT_W-1:0]        w_word;
   logic [SLOT_W-1:0]        w_slot_bits;
   logic                     w_lj_next;
   logic                     w_lrck_next;

   assign w_fall      = r_sck && (r_sck_cnt == '0);
   assign w_wrap      = w_fall && (r_b == B_LAST);
   assign w_b_next    = (r_b == B_LAST) ? '0 : r_b + BW'(1);
   assign w_b_next2   = (w_b_next == B_LAST) ? '0 : w_b_next + BW'(1);
   assign w_pos_next  = (r_pos == P_LAST) ? '0 : r_pos + PW'(1);
   assign w_enough    = r_level >= LW'(CHANNELS);
   assign w_act_next  = w_wrap ? w_enough : r_frame_act;
   assign w_pop       = w_fall && (w_pos_next == '0) && w_act_next;
   assign w_push      = s_valid && s_ready;

   // Sample is MSB-aligned in the slot; the FIFO head is used only at a slot start.
   assign w_cat       = {r_mem[r_rd], {SLOT_W{1'b0}}};
   assign w_word      = w_cat[DATA_W+SLOT_W-1 -: SLOT_W];
   assign w_slot_bits = (w_pos_next == '0) ? (w_act_next ? w_word : '0) : r_shift;
   assign w_lj_next   = w_slot_bits[SLOT_W-1];
   assign w_lrck_next = (FMT == 1) ? (w_b_next >= B_HALF) : (w_b_next2 >= B_HALF);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_mclk_cnt <= MCW'(MH - 1);
         r_mclk     <= 1'b0;
      end else if (r_mclk_cnt == '0) begin
         r_mclk_cnt <= MCW'(MH - 1);
         r_mclk     <= ~r_mclk;
      end else begin
         r_mclk_cnt <= r_mclk_cnt - MCW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sck_cnt <= SCW'(SH - 1);
         r_sck     <= 1'b0;
      end else if (r_sck_cnt == '0) begin
         r_sck_cnt <= SCW'(SH - 1);
         r_sck     <= ~r_sck;
      end else begin
         r_sck_cnt <= r_sck_cnt - SCW'(1);
      end
   end

   // In I2S mode sdout lags the left-justified stream by one bit via r_lj.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_b         <= '0;
         r_pos       <= '0;
         r_frame_act <= 1'b0;
         r_shift     <= '0;
         r_lj        <= 1'b0;
         r_sdout     <= 1'b0;
         r_lrck      <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_underrun <= w_wrap && !w_enough;
         if (w_fall) begin
            r_b         <= w_b_next;
            r_pos       <= w_pos_next;
            r_frame_act <= w_act_next;
            r_shift     <= {w_slot_bits[SLOT_W-2:0], 1'b0};
            r_lj        <= w_lj_next;
            r_sdout     <= (FMT == 1) ? w_lj_next : r_lj;
            r_lrck      <= w_lrck_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         r_level <= r_level + LW'(w_push) - LW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= s_data;
   end

   assign s_ready  = r_level < LW'(FIFO_DEPTH);
   assign mclk     = r_mclk;
   assign sck      = r_sck;
   assign lrck     = r_lrck;
   assign sdout    = r_sdout;
   assign underrun = r_underrun;
   assign level    = r_level;

endmodule

// File: tb/tb_i2s_tx.sv
`timescale 1ns/1ps
// Bench for i2s_tx: default I2S instance (A) and a 4-slot left-justified TDM instance (B).
module tb_i2s_tx;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [23:0] sd_a_in = '0;
   logic        sv_a = 1'b0;
   logic        rdy_a, mclk_a, sck_a, lrck_a, sdo_a, und_a;
   logic [2:0]  lvl_a;
   logic [23:0] sd_b_in = '0;
   logic        sv_b = 1'b0;
   logic        rdy_b, mclk_b, sck_b, lrck_b, sdo_b, und_b;
   logic [2:0]  lvl_b;

   i2s_tx dut_a (
      .clk(clk), .rst(rst), .s_data(sd_a_in), .s_valid(sv_a), .s_ready(rdy_a),
      .mclk(mclk_a), .sck(sck_a), .lrck(lrck_a), .sdout(sdo_a), .underrun(und_a), .level(lvl_a)
   );

   i2s_tx #(.CHANNELS(4), .FMT(1)) dut_b (
      .clk(clk), .rst(rst), .s_data(sd_b_in), .s_valid(sv_b), .s_ready(rdy_b),
      .mclk(mclk_b), .sck(sck_b), .lrck(lrck_b), .sdout(sdo_b), .underrun(und_b), .level(lvl_b)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic finish_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   // Per-sck-rise capture: bit index counts from reset release.
   logic sdr_a [1024];
   logic lrr_a [1024];
   int   ucr_a [1024];
   int   ri_a = 0, uc_a = 0;
   logic sq_a = 1'b0;
   logic sdr_b [1024];
   logic lrr_b [1024];
   int   ucr_b [1024];
   int   ri_b = 0, uc_b = 0;
   logic sq_b = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         ri_a = 0; uc_a = 0; sq_a = 1'b0;
      end else begin
         if (und_a) uc_a++;
         if (sck_a && !sq_a && ri_a < 1024) begin
            sdr_a[ri_a] = sdo_a; lrr_a[ri_a] = lrck_a; ucr_a[ri_a] = uc_a; ri_a++;
         end
         sq_a = sck_a;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         ri_b = 0; uc_b = 0; sq_b = 1'b0;
      end else begin
         if (und_b) uc_b++;
         if (sck_b && !sq_b && ri_b < 1024) begin
            sdr_b[ri_b] = sdo_b; lrr_b[ri_b] = lrck_b; ucr_b[ri_b] = uc_b; ri_b++;
         end
         sq_b = sck_b;
      end
   end

   task automatic wait_rise_a(input int n);
      int t = 0;
      while (ri_a < n && t < 40000) begin @(negedge clk); #1; t++; end
      if (ri_a < n) begin
         checks++; errors++;
         $display("FAIL timeout_a: got %0d sck rises expected %0d", ri_a, n);
         finish_run();
      end
   endtask

   task automatic wait_rise_b(input int n);
      int t = 0;
      while (ri_b < n && t < 40000) begin @(negedge clk); #1; t++; end
      if (ri_b < n) begin
         checks++; errors++;
         $display("FAIL timeout_b: got %0d sck rises expected %0d", ri_b, n);
         finish_run();
      end
   endtask

   task automatic push_a(input logic [23:0] d);
      sd_a_in = d; sv_a = 1'b1;
      @(posedge clk); #1;
      sv_a = 1'b0;
   endtask

   task automatic push_b(input logic [23:0] d);
      sd_b_in = d; sv_b = 1'b1;
      @(posedge clk); #1;
      sv_b = 1'b0;
   endtask

   // Left-justified bit i of a 2-slot frame (24-bit samples in 32-bit slots).
   function automatic logic lj2(input logic [23:0] d0, input logic [23:0] d1, input int i);
      int p;
      p = i % 32;
      if (p >= 24) return 1'b0;
      return (i < 32) ? d0[23-p] : d1[23-p];
   endfunction

   typedef struct {
      int          edge_n;
      logic        sck;
      logic        mclk;
   } tvec_t;

   typedef struct {
      int          npush;
      logic [23:0] d0;
      logic [23:0] d1;
   } fvec_t;

   tvec_t       tv [7];
   fvec_t       fv [6];
   logic        exp_a [1024];
   logic [23:0] q [$];
   logic [23:0] bd [4];
   logic [23:0] src [6];
   int          acc_e [6];

   initial begin
      tv[0] = '{1, 1'b0, 1'b0};
      tv[1] = '{2, 1'b0, 1'b1};
      tv[2] = '{3, 1'b0, 1'b1};
      tv[3] = '{4, 1'b1, 1'b0};
      tv[4] = '{6, 1'b1, 1'b1};
      tv[5] = '{8, 1'b0, 1'b0};
      tv[6] = '{12, 1'b1, 1'b0};

      fv[0] = '{2, 24'hA5A5A5, 24'h123456};
      fv[1] = '{0, 24'h000000, 24'h000000};
      fv[2] = '{2, 24'h800000, 24'h7FFFFF};
      fv[3] = '{1, 24'hFFFFFF, 24'h000000};
      fv[4] = '{1, 24'h000001, 24'h000000};
      fv[5] = '{2, 24'h5A5A5A, 24'hC3C3C3};

      bd[0] = 24'h800001; bd[1] = 24'h3C3C3C; bd[2] = 24'hFEDCBA; bd[3] = 24'h0F0F0F;
      src[0] = 24'h111111; src[1] = 24'h222222; src[2] = 24'h333333;
      src[3] = 24'h444444; src[4] = 24'h555555; src[5] = 24'h666666;

      // Reset values
      repeat (4) @(negedge clk);
      chk("rst_mclk", 128'(mclk_a), 128'(0));
      chk("rst_sck", 128'(sck_a), 128'(0));
      chk("rst_lrck", 128'(lrck_a), 128'(0));
      chk("rst_sdout", 128'(sdo_a), 128'(0));
      chk("rst_underrun", 128'(und_a), 128'(0));
      chk("rst_level", 128'(lvl_a), 128'(0));
      chk("rst_ready", 128'(rdy_a), 128'(1));
      chk("rst_b_sck", 128'(sck_b), 128'(0));
      chk("rst_b_level", 128'(lvl_b), 128'(0));
      chk("rst_b_ready", 128'(rdy_b), 128'(1));

      // Clock generation after release
      rst = 1'b1;
      begin
         int e = 0;
         for (int i = 0; i < 7; i++) begin
            while (e < tv[i].edge_n) begin @(posedge clk); e++; end
            #1;
            chk($sformatf("sck_e%0d", tv[i].edge_n), 128'(sck_a), 128'(tv[i].sck));
            chk($sformatf("mclk_e%0d", tv[i].edge_n), 128'(mclk_a), 128'(tv[i].mclk));
         end
      end

      fork
         begin : thread_a
            logic [23:0] f0, f1;
            logic        act;
            for (int k = 0; k < 7; k++) begin
               wait_rise_a(64*k + 1);
               if (k == 0) begin
                  act = 1'b0; f0 = '0; f1 = '0;
                  chk("a_und_f0", 128'(ucr_a[0]), 128'(0));
               end else begin
                  if (q.size() >= 2) begin
                     f0 = q.pop_front(); f1 = q.pop_front(); act = 1'b1;
                  end else begin
                     f0 = '0; f1 = '0; act = 1'b0;
                  end
                  chk($sformatf("a_und_f%0d", k), 128'(ucr_a[64*k] - ucr_a[64*(k-1)]),
                      act ? 128'(0) : 128'(1));
               end
               for (int b = 0; b < 64; b++)
                  exp_a[64*k + b] = (b == 0 || !act) ? 1'b0 : lj2(f0, f1, b - 1);
               if (k < 6) begin
                  for (int j = 0; j < fv[k].npush; j++) begin
                     push_a(j == 0 ? fv[k].d0 : fv[k].d1);
                     q.push_back(j == 0 ? fv[k].d0 : fv[k].d1);
                  end
               end
               wait_rise_a(64*k + 41);
               chk($sformatf("a_level_f%0d", k), 128'(lvl_a), 128'(q.size()));
            end
            wait_rise_a(64*7);
            for (int k = 0; k < 7; k++) begin
               logic [63:0] as, es, al, el;
               for (int b = 0; b < 64; b++) begin
                  as[63-b] = sdr_a[64*k + b];
                  es[63-b] = exp_a[64*k + b];
                  al[63-b] = lrr_a[64*k + b];
                  el[63-b] = (((b + 1) % 64) >= 32);
               end
               chk($sformatf("a_sdout_f%0d", k), 128'(as), 128'(es));
               chk($sformatf("a_lrck_f%0d", k), 128'(al), 128'(el));
            end
         end
         begin : thread_b
            logic [127:0] as, es, al, el;
            wait_rise_b(1);
            chk("b_und_f0", 128'(ucr_b[0]), 128'(0));
            for (int j = 0; j < 3; j++) push_b(bd[j]);
            wait_rise_b(129);
            chk("b_und_f1", 128'(ucr_b[128] - ucr_b[0]), 128'(1));
            chk("b_level_3", 128'(lvl_b), 128'(3));
            push_b(bd[3]);
            wait_rise_b(257);
            chk("b_und_f2", 128'(ucr_b[256] - ucr_b[128]), 128'(0));
            wait_rise_b(385);
            chk("b_und_f3", 128'(ucr_b[384] - ucr_b[256]), 128'(1));
            chk("b_level_end", 128'(lvl_b), 128'(0));
            for (int b = 0; b < 128; b++) begin
               as[127-b] = sdr_b[128 + b];
            end
            chk("b_sdout_f1", as, 128'(0));
            for (int b = 0; b < 128; b++) begin
               as[127-b] = sdr_b[256 + b];
               es[127-b] = ((b % 32) < 24) ? bd[b/32][23 - (b % 32)] : 1'b0;
               al[127-b] = lrr_b[256 + b];
               el[127-b] = (b >= 64);
            end
            chk("b_sdout_f2", as, es);
            chk("b_lrck_f2", al, el);
         end
      join

      // Reset mid-frame at b=20 with three samples buffered
      @(negedge clk); #1;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      wait_rise_a(1);
      for (int j = 0; j < 3; j++) push_a(24'hABCDEF);
      wait_rise_a(21);
      chk("mid_level_pre", 128'(lvl_a), 128'(3));
      rst = 1'b0;
      @(posedge clk); #1;
      chk("mid_sck", 128'(sck_a), 128'(0));
      chk("mid_mclk", 128'(mclk_a), 128'(0));
      chk("mid_lrck", 128'(lrck_a), 128'(0));
      chk("mid_sdout", 128'(sdo_a), 128'(0));
      chk("mid_underrun", 128'(und_a), 128'(0));
      chk("mid_level", 128'(lvl_a), 128'(0));
      chk("mid_ready", 128'(rdy_a), 128'(1));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      wait_rise_a(65);
      begin
         logic [63:0] as;
         for (int b = 0; b < 64; b++) as[63-b] = sdr_a[b];
         chk("mid_sdout_f0", 128'(as), 128'(0));
      end
      chk("mid_und_f0", 128'(ucr_a[0]), 128'(0));
      chk("mid_und_f1", 128'(ucr_a[64] - ucr_a[0]), 128'(1));

      // Backpressure: six samples held on s_valid from release
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      for (int j = 0; j < 6; j++) acc_e[j] = -1;
      q.delete();
      rst = 1'b1;
      sd_a_in = src[0];
      sv_a = 1'b1;
      fork
         begin : bp_push
            int  e = 0, idx = 0;
            logic wa;
            while (idx < 6 && e < 1000) begin
               wa = sv_a && rdy_a;
               @(posedge clk); e++; #1;
               if (wa) begin
                  acc_e[idx] = e; idx++;
                  if (idx < 6) sd_a_in = src[idx];
                  else sv_a = 1'b0;
               end
               if (e == 10) begin
                  chk("bp_level_full", 128'(lvl_a), 128'(4));
                  chk("bp_ready_full", 128'(rdy_a), 128'(0));
               end
               @(negedge clk);
            end
            sv_a = 1'b0;
         end
         begin : bp_cap
            wait_rise_a(257);
            for (int f = 1; f < 4; f++) begin
               logic [63:0] as, es;
               for (int b = 0; b < 64; b++) begin
                  as[63-b] = sdr_a[64*f + b];
                  es[63-b] = (b == 0) ? 1'b0 : lj2(src[2*f-2], src[2*f-1], b - 1);
               end
               chk($sformatf("bp_sdout_f%0d", f), 128'(as), 128'(es));
               chk($sformatf("bp_und_f%0d", f), 128'(ucr_a[64*f] - ucr_a[64*(f-1)]), 128'(0));
            end
            chk("bp_und_f4", 128'(ucr_a[256] - ucr_a[192]), 128'(1));
            chk("bp_level_end", 128'(lvl_a), 128'(0));
         end
      join
      begin
         int exp_acc [6];
         exp_acc = '{1, 2, 3, 4, 513, 769};
         for (int j = 0; j < 6; j++)
            chk($sformatf("bp_accept_%0d", j), 128'(acc_e[j]), 128'(exp_acc[j]));
      end

      finish_run();
   end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter DATA_W, default 24: sample width in bits, 16..32, and not greater than SLOT_W.
REQ-002 Parameter SLOT_W, default 32: sck bits per channel slot.
REQ-003 Parameter CHANNELS, default 2: slots per frame, even, 2..8; values above 2 give TDM.
REQ-004 Parameter SCK_DIV, default 8: clk cycles per sck period, even, at least 2.
REQ-005 Parameter MCLK_DIV, default 4: clk cycles per mclk period, even, at least 2.
REQ-006 Parameter FMT, default 0: 0 = I2S (1-bit delay), 1 = left-justified.
REQ-007 Parameter FIFO_DEPTH, default 4: sample FIFO entries, a power of 2, at least CHANNELS.
REQ-008 clk  in  1  system clock, 100 MHz.
REQ-009 rst  in  1  synchronous, active-low reset.
REQ-010 s_data  in  DATA_W  sample, two's complement; channels written in slot order 0..CHANNELS-1.
REQ-011 s_valid  in  1  s_data is valid.
REQ-012 s_ready  out  1  FIFO can accept a sample.
REQ-013 mclk  out  1  master clock for the codec.
REQ-014 sck  out  1  bit clock.
REQ-015 lrck  out  1  frame sync / word select.
REQ-016 sdout  out  1  serial data, MSB first.
REQ-017 underrun  out  1  one-clk pulse when a zero frame is emitted because of starvation.
REQ-018 level  out  clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Function
REQ-019 mclk SHALL toggle every MCLK_DIV/2 clk cycles; it is low in reset.
REQ-020 sck SHALL be free-running, low in reset, rising SCK_DIV/2 clks after reset release, with period SCK_DIV clks.
REQ-021 Bit index b SHALL run 0..FB-1, where FB = SLOT_W*CHANNELS, advancing on each sck falling edge and wrapping from FB-1 to 0.
REQ-022 sdout and lrck SHALL change only on the clk cycle where sck falls, and SHALL be stable while sck is high.
REQ-023 When FMT=1, lrck SHALL be 1 iff b >= FB/2.
REQ-024 When FMT=0, lrck SHALL be 1 iff ((b+1) mod FB) >= FB/2, i.e. one bit early.
REQ-025 Left-justified stream, slot s = b/SLOT_W, p = b mod SLOT_W: bits with p < DATA_W carry sample[s] bit DATA_W-1-p; all other bits are 0.
REQ-026 When FMT=1, sdout SHALL be the left-justified stream.
REQ-027 When FMT=0, sdout SHALL be the left-justified stream delayed by one sck period; the final bit of a frame appears at b=0 of the next frame.
REQ-028 Frame decision at each wrap to b=0: if level >= CHANNELS, the next frame SHALL pop CHANNELS samples, one at each slot start.
REQ-029 Frame decision at each wrap to b=0: if level < CHANNELS, the next frame SHALL be all zeros, nothing is popped, and underrun pulses for 1 clk on the wrap cycle.
REQ-030 The first frame after reset SHALL be all zeros, with no underrun pulse.
REQ-031 Push occurs on s_valid && s_ready.
REQ-032 s_ready SHALL be 1 iff level < FIFO_DEPTH.
REQ-033 A push and a pop in the same cycle SHALL leave level unchanged.
REQ-034 A push while full SHALL NOT occur, since s_ready=0; s_data SHALL be held by the source until accepted.
REQ-035 level SHALL update on the clk after a push or pop.

Reset
REQ-036 While rst=0, all of the following SHALL hold: mclk=0, sck=0, lrck=0, sdout=0, underrun=0, b=0, level=0, s_ready=1, FIFO emptied.
REQ-037 Reset asserted mid-frame SHALL take effect on the next clk edge, discarding the partial frame and all buffered samples.
REQ-038 Operation SHALL restart per REQ-020 and REQ-030 after reset release.

Verification (defaults unless stated; FB=64, frame = 512 clk)
REQ-039 Reset: rst=0 for 4 clk -> all outputs at reset values, s_ready=1; after release the first sck rising edge occurs at clk 4 and the first frame is all zeros.
REQ-040 Push 0xA5A5A5 then 0x123456 during frame 0 -> frame 1, sampled at sck rising edges:
  - lrck=0 slot: 1 delay bit, then 24 bits of A5A5A5 MSB first, then 7 zeros;
  - lrck=1 slot: 1 delay bit, then 123456, then zeros;
  - level returns to 0.
REQ-041 No pushes -> zero frames; underrun pulses exactly 1 clk at every wrap to b=0, every 512 clk.
REQ-042 Hold s_valid=1 with 6 samples in the source -> 4 accepted, then s_ready=0 and level=4; the 5th sample is accepted on the clk after the first pop; no sample is lost or duplicated.
REQ-043 FMT=1, CHANNELS=4, 3 samples queued -> the frame is zero with an underrun pulse.
REQ-044 FMT=1, CHANNELS=4, a 4th sample added -> the next frame carries all 4 samples:
  - lrck=0 for 64 bits, then 1 for 64 bits;
  - each MSB coincides with its slot start.
REQ-045 Reset mid-frame at b=20 with level=3 -> on the next clk all outputs are at reset values and level=0; the frame after release is zero with no underrun pulse.
